// File: rtl/avl_mem_master.sv
// ---------------------------------------------------------------------------
// avl_mem_master
//   The CPU's single Avalon-MM master port. Arbitrates between the
//   instruction-fetch port (i_*) and the data load/store port (d_*), data
//   first, and issues one Avalon read or write per request. Misaligned or
//   illegal requests are answered with an error ack and never reach the bus.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_req/i_addr          fetch request (held until i_ack) and byte address
//   i_rdata/i_ack/i_err   fetched word, one-cycle completion pulse, error
//   d_req/d_we/d_addr     data request, 1=store, byte address
//   d_size/d_signed       00 byte, 01 half, 10 word, 11 illegal; sign-extend
//   d_wdata               right-justified store data
//   d_rdata/d_ack/d_err   load result, one-cycle completion pulse, error
//   avm_*                 Avalon-MM master signals
//
// Parameter
//   WAIT_TIMEOUT          consecutive waitrequest-high bus cycles before the
//                         transaction aborts with an error; 0 disables it
// ---------------------------------------------------------------------------
module avl_mem_master #(
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  output logic        avm_write,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [2:0] {IDLE, BUS_I, BUS_D, ACK_I, ACK_D} state_t;

  localparam logic [31:0] TO_LAST = (WAIT_TIMEOUT == 0) ? 32'd0 : 32'(WAIT_TIMEOUT - 1);

  state_t      state, state_n;
  logic [1:0]  lane, lane_n;        // byte offset of the access within the word
  logic [1:0]  size, size_n;        // fetches are recorded as word accesses
  logic        sgn, sgn_n;
  logic [31:0] wait_cnt, wait_cnt_n;

  logic [31:0] i_rdata_n, d_rdata_n, avm_address_n, avm_writedata_n;
  logic [3:0]  avm_byteenable_n;
  logic        i_ack_n, i_err_n, d_ack_n, d_err_n, avm_read_n, avm_write_n;
  logic        d_bad;

  // Right-align the addressed lane, then extend byte/half results.
  function automatic logic [31:0] fmt_load(input logic [31:0] raw, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (sz)
      2'b00:   return {{24{sg & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{sg & sh[15]}}, sh[15:0]};
      default: return raw;
    endcase
  endfunction

  assign d_bad = (d_size == 2'b11) || (d_size == 2'b01 && d_addr[0]) ||
                 (d_size == 2'b10 && d_addr[1:0] != 2'b00);

  // NOTE: every variable gets its default first so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_n          = state;
    lane_n           = lane;
    size_n           = size;
    sgn_n            = sgn;
    wait_cnt_n       = wait_cnt;
    i_rdata_n        = i_rdata;
    d_rdata_n        = d_rdata;
    i_ack_n          = 1'b0;
    i_err_n          = 1'b0;
    d_ack_n          = 1'b0;
    d_err_n          = 1'b0;
    avm_address_n    = avm_address;
    avm_byteenable_n = avm_byteenable;
    avm_writedata_n  = avm_writedata;
    avm_read_n       = avm_read;
    avm_write_n      = avm_write;

    case (state)
      IDLE: begin
        wait_cnt_n = '0;
        if (d_req) begin
          if (d_bad) begin
            d_ack_n   = 1'b1;
            d_err_n   = 1'b1;
            d_rdata_n = '0;
            state_n   = ACK_D;
          end else begin
            avm_address_n = {d_addr[31:2], 2'b00};
            case (d_size)
              2'b00: begin
                avm_byteenable_n = 4'b0001 << d_addr[1:0];
                avm_writedata_n  = {4{d_wdata[7:0]}};
              end
              2'b01: begin
                avm_byteenable_n = 4'b0011 << {d_addr[1], 1'b0};
                avm_writedata_n  = {2{d_wdata[15:0]}};
              end
              default: begin
                avm_byteenable_n = 4'b1111;
                avm_writedata_n  = d_wdata;
              end
            endcase
            avm_read_n  = ~d_we;
            avm_write_n = d_we;
            lane_n      = d_addr[1:0];
            size_n      = d_size;
            sgn_n       = d_signed;
            state_n     = BUS_D;
          end
        end else if (i_req) begin
          if (i_addr[1:0] != 2'b00) begin
            i_ack_n   = 1'b1;
            i_err_n   = 1'b1;
            i_rdata_n = '0;
            state_n   = ACK_I;
          end else begin
            avm_address_n    = i_addr;
            avm_byteenable_n = 4'b1111;
            avm_writedata_n  = '0;
            avm_read_n       = 1'b1;
            avm_write_n      = 1'b0;
            lane_n           = 2'b00;
            size_n           = 2'b10;
            sgn_n            = 1'b0;
            state_n          = BUS_I;
          end
        end
      end

      BUS_I, BUS_D: begin
        if (!avm_waitrequest) begin
          avm_read_n  = 1'b0;
          avm_write_n = 1'b0;
          if (state == BUS_I) begin
            i_ack_n   = 1'b1;
            i_rdata_n = avm_readdata;
            state_n   = ACK_I;
          end else begin
            d_ack_n   = 1'b1;
            d_rdata_n = avm_write ? 32'd0 : fmt_load(avm_readdata, lane, size, sgn);
            state_n   = ACK_D;
          end
        end else if (WAIT_TIMEOUT != 0 && wait_cnt == TO_LAST) begin
          avm_read_n  = 1'b0;
          avm_write_n = 1'b0;
          if (state == BUS_I) begin
            i_ack_n   = 1'b1;
            i_err_n   = 1'b1;
            i_rdata_n = '0;
            state_n   = ACK_I;
          end else begin
            d_ack_n   = 1'b1;
            d_err_n   = 1'b1;
            d_rdata_n = '0;
            state_n   = ACK_D;
          end
        end else begin
          wait_cnt_n = wait_cnt + 32'd1;
        end
      end

      // The ack pulse ends here; the next request is sampled back in IDLE.
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lane           <= '0;
      size           <= '0;
      sgn            <= 1'b0;
      wait_cnt       <= '0;
      i_rdata        <= '0;
      i_ack          <= 1'b0;
      i_err          <= 1'b0;
      d_rdata        <= '0;
      d_ack          <= 1'b0;
      d_err          <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
    end else begin
      state          <= state_n;
      lane           <= lane_n;
      size           <= size_n;
      sgn            <= sgn_n;
      wait_cnt       <= wait_cnt_n;
      i_rdata        <= i_rdata_n;
      i_ack          <= i_ack_n;
      i_err          <= i_err_n;
      d_rdata        <= d_rdata_n;
      d_ack          <= d_ack_n;
      d_err          <= d_err_n;
      avm_address    <= avm_address_n;
      avm_byteenable <= avm_byteenable_n;
      avm_writedata  <= avm_writedata_n;
      avm_read       <= avm_read_n;
      avm_write      <= avm_write_n;
    end
  end

endmodule

// File: doc/avl_mem_master.md
Name: avl_mem_master

Overview:
- Upstream neighbour of the Avalon memory slave: the CPU's single Avalon master port.
- Arbitrates between the instruction-fetch port and the data (load/store) port.
- Converts each request into one Avalon read/write with word-aligned address, byteenable and lane-replicated writedata.
- Holds bus signals stable through waitrequest, then returns aligned, extended load data with a one-cycle ack.

Parameters:
- WAIT_TIMEOUT, 0, consecutive waitrequest-high cycles before a transaction aborts with error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_req  in  1  instruction fetch request; held stable until i_ack
- i_addr  in  32  fetch byte address
- i_rdata  out  32  fetched word; valid while i_ack=1
- i_ack  out  1  one-cycle fetch completion pulse
- i_err  out  1  with i_ack: misaligned fetch or timeout
- d_req  in  1  data request; held stable until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  32  data byte address
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_signed  in  1  sign-extend byte/half loads
- d_wdata  in  32  store data, right-justified
- d_rdata  out  32  load result; valid while d_ack=1
- d_ack  out  1  one-cycle data completion pulse
- d_err  out  1  with d_ack: misaligned/illegal size or timeout
- avm_address  out  32  word-aligned byte address
- avm_byteenable  out  4  lane enables, bit0 = byte at address+0 = data[7:0]
- avm_writedata  out  32  store data, lane-replicated
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_readdata  in  32  Avalon read data
- avm_waitrequest  in  1  Avalon wait

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
- All outputs are registered and reset to 0. State resets to IDLE and the timeout counter to 0.
- Reset mid-transaction: next edge drops avm_read/avm_write, no ack issued, and the request is forgotten.
- States: IDLE, BUS_I, BUS_D, ACK_I, ACK_D.
- IDLE arbitration:
  - If d_req=1, d_req wins (fixed priority, data over fetch); else i_req.
  - A misaligned or illegal request goes straight to ACK_x with err=1 and no bus cycle.
  - Misaligned means: half with addr[0]=1; word with addr[1:0]!=0; d_size=11; fetch with i_addr[1:0]!=0.
  - An aligned request latches avm_* and enters BUS_x; avm_read or avm_write (never both) is 1 from the next cycle.
- Bus encoding:
  - avm_address={addr[31:2],2'b00}.
  - byteenable: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word and fetch 1111.
  - writedata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- BUS_x:
  - avm_* held constant while avm_waitrequest=1.
  - The completion cycle is the first cycle with avm_waitrequest=0 while read/write is asserted.
  - On that edge: deassert read/write, capture formatted data, go to ACK_x.
- Load formatting: shift avm_readdata right by 8*addr[1:0], then zero- or sign-extend from bit 7 (byte) or bit 15 (half) per d_signed. Word loads and fetches pass through unchanged. Stores return d_rdata=0.
- ACK_x: x_ack=1 for exactly one cycle, with rdata/err; then IDLE. A new request is sampled in IDLE the following cycle, so a requester updating on ack causes no duplicate transaction.
- Timeout: if WAIT_TIMEOUT>0 and waitrequest stays high WAIT_TIMEOUT consecutive BUS cycles, drop read/write and go to ACK_x with err=1.
- Throughput: at most one outstanding transaction. The non-selected port waits, with its ack held at 0.
- Latency against a slave asserting waitrequest for 2 cycles then 0:
  - request sampled at T0;
  - avm_read high T1–T3;
  - completion at T3;
  - ack at T4.

Test Plan:
- Word fetch: i_addr=BFC00004 with slave instr bytes 04..07 = 78 56 34 12 -> avm_read=1, byteenable=1111, address=BFC00004; i_ack at T4 with i_rdata=12345678, i_err=0.
- Store byte, then signed load: d_we=1, d_addr=00000102, d_size=00, d_wdata=000000F0 -> byteenable=0100, writedata=F0F0F0F0. Then d_we=0, d_signed=1 -> d_rdata=FFFFFFF0; with d_signed=0 -> d_rdata=000000F0.
- Half store/load: d_addr=00000202, d_size=01, d_wdata=0000ABCD -> byteenable=1100, writedata=ABCDABCD. Reload with d_signed=1 -> d_rdata=FFFFABCD.
- Simultaneous requests: i_req=1 and d_req=1 in the same IDLE cycle -> data transaction first with d_ack only. The fetch starts in the IDLE cycle after d_ack and completes with i_ack; no duplicate bus cycle.
- Misalignment: d_addr=00000001, d_size=10 -> d_ack=1, d_err=1 one cycle after sampling, with avm_read/avm_write never asserted. Same for d_size=11 and i_addr=BFC00002.
- Timeout/reset:
  - WAIT_TIMEOUT=5, waitrequest tied 1 -> read drops and d_ack with d_err=1 after 5 cycles.
  - Separately, asserting rst while in BUS_D -> all avm_* and acks 0 on the next edge, state IDLE.
